pipelined_adder_n: RTL



---
 rtl/padd_pkg.sv | 23 ++
 rtl/adder_chunk.sv | 31 +++
 rtl/pipelined_adder_n.sv | 133 +++++++++++++
 3 files changed

// File: rtl/padd_pkg.sv
// padd_pkg: shared mode constants, per-stage control bundle and helpers
// for pipelined_adder_n and adder_chunk.
package padd_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Control bits that travel with an operation from stage to stage.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_ctl_t;

  // Subtraction is A + ~B + 1, so borrow-in flips the slice-0 carry.
  function automatic logic eff_carry(
    input logic cin,
    input logic mode
  );
    return (mode == SUB) ? ~cin : cin;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple adder.
// Ports: a, b, cin in; s, cout, msb_cin (carry into the top bit) out.
module adder_chunk
  import padd_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// pipelined_adder_n: WIDTH-bit add/sub, one CHUNK-bit slice per stage,
// valid/ready both sides; define PADD_SAT_EN to saturate s on overflow.
module pipelined_adder_n
  import padd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             stall;
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             v_q  [STAGES];
  logic             cy_q [STAGES];
  logic             ov_q [STAGES];

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;
  assign b_eff    = (sub == ADD) ? b : ~b;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = CHUNK * k;
    localparam int REM = WIDTH - LO - CHUNK;

    // a_in/b_in hold this slice plus the upper slices still to come.
    logic [WIDTH-LO-1:0]  a_in;
    logic [WIDTH-LO-1:0]  b_in;
    logic [LO+CHUNK-1:0]  res_nxt;
    logic [LO+CHUNK-1:0]  res_ld;
    logic [LO+CHUNK-1:0]  res_r;
    logic [CHUNK-1:0]     sum;
    logic                 c_i;
    logic                 c_o;
    logic                 c_msb;
    logic                 v_i;
    stage_ctl_t           ctl;

    if (k == 0) begin : g_head
      assign a_in    = a;
      assign b_in    = b_eff;
      assign c_i     = eff_carry(c_in, sub);
      assign v_i     = in_valid;
      assign res_nxt = sum;
    end else begin : g_body
      assign a_in    = g_st[k-1].g_op.a_r;
      assign b_in    = g_st[k-1].g_op.b_r;
      assign c_i     = cy_q[k-1];
      assign v_i     = v_q[k-1];
      assign res_nxt = {sum, g_st[k-1].res_r};
    end

    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a      (a_in[CHUNK-1:0]),
      .b      (b_in[CHUNK-1:0]),
      .cin    (c_i),
      .s      (sum),
      .cout   (c_o),
      .msb_cin(c_msb)
    );

    if (REM > 0) begin : g_op
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;

      always_ff @(posedge clk) begin
        if (en && v_i) begin
          a_r <= a_in[WIDTH-LO-1:CHUNK];
          b_r <= b_in[WIDTH-LO-1:CHUNK];
        end
      end
    end

`ifdef PADD_SAT_EN
    if (k == STAGES - 1) begin : g_sat
      // Positive overflow only when A is non-negative.
      always_comb begin
        res_ld = res_nxt;
        if (c_msb ^ c_o) begin
          res_ld = {a_in[CHUNK-1], {(WIDTH-1){~a_in[CHUNK-1]}}};
        end
      end
    end else begin : g_wrap
      assign res_ld = res_nxt;
    end
`else
    assign res_ld = res_nxt;
`endif

    // Data only loads with a valid op so bubbles leave outputs untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctl   <= '0;
        res_r <= '0;
      end else if (en) begin
        ctl.valid <= v_i;
        if (v_i) begin
          ctl.carry <= c_o;
          ctl.ovf   <= c_msb ^ c_o;
          res_r     <= res_ld;
        end
      end
    end

    assign v_q[k]  = ctl.valid;
    assign cy_q[k] = ctl.carry;
    assign ov_q[k] = ctl.ovf;
  end

  assign out_valid = v_q[STAGES-1];
  assign c_out     = cy_q[STAGES-1];
  assign ovf       = ov_q[STAGES-1];
  assign s         = g_st[STAGES-1].res_r;

endmodule
